prio_encoder_rr: RTL



---
 rtl/prio_pkg.sv | 12 +
 rtl/prio_find.sv | 37 +++
 rtl/prio_encoder_rr.sv | 73 +++++++
 3 files changed

// File: rtl/prio_pkg.sv
// Shared definitions for the registered priority encoder / round-robin arbiter.
// Mode encodings and a width helper that never returns zero.
package prio_pkg;

  localparam logic PRIO_FIXED = 1'b0;
  localparam logic PRIO_RR    = 1'b1;

  function automatic int safe_clog2(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/prio_find.sv
// Combinational first-set search over a request vector, descending from a start
// position and wrapping from 0 back to N-1.
module prio_find
  import prio_pkg::*;
#(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic         found,
  output logic [W-1:0] idx
);

  logic [W-1:0] w_start_c;

  // Position k steps below s, modulo N.
  function automatic logic [W-1:0] step_down(input logic [W-1:0] s, input int k);
    int p;
    p = (int'(s) + N - k) % N;
    return W'(p);
  endfunction

  assign w_start_c = (int'(start) >= N) ? W'(N - 1) : start;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      if (!found && req[step_down(w_start_c, k)]) begin
        found = 1'b1;
        idx   = step_down(w_start_c, k);
      end
    end
  end

endmodule

// File: rtl/prio_encoder_rr.sv
// Registered N-to-log2(N) priority encoder with fixed-priority or round-robin
// selection; the grant register holds until the consumer accepts it.
module prio_encoder_rr
  import prio_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = safe_clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] out_onehot
);

  logic         r_valid;
  logic [W-1:0] r_idx;
  logic [N-1:0] r_onehot;
  logic [W-1:0] r_ptr;

  logic         w_accept;
  logic         w_load;
  logic [W-1:0] w_ptr_nxt;
  logic [W-1:0] w_start;
  logic         w_found;
  logic [W-1:0] w_idx;

  function automatic logic [W-1:0] dec_wrap(input logic [W-1:0] i);
    return (i == '0) ? W'(N - 1) : (i - W'(1));
  endfunction

  assign w_accept = r_valid & out_ready;
  assign w_load   = ~r_valid | out_ready;

  // The pointer update from an accept is forwarded into the same-edge search,
  // so back-to-back grants rotate without a bubble.
  assign w_ptr_nxt = w_accept ? dec_wrap(r_idx) : r_ptr;
  assign w_start   = (mode == PRIO_RR) ? w_ptr_nxt : W'(N - 1);

  prio_find #(
    .N(N),
    .W(W)
  ) u_find (
    .req  (req),
    .start(w_start),
    .found(w_found),
    .idx  (w_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid  <= 1'b0;
      r_idx    <= '0;
      r_onehot <= '0;
      r_ptr    <= W'(N - 1);
    end else begin
      if (w_load) begin
        r_valid  <= w_found;
        r_idx    <= w_found ? w_idx : '0;
        r_onehot <= w_found ? (N'(1) << w_idx) : '0;
      end
      r_ptr <= (mode == PRIO_RR) ? w_ptr_nxt : W'(N - 1);
    end
  end

  assign out_valid  = r_valid;
  assign out_idx    = r_idx;
  assign out_onehot = r_onehot;

endmodule
